// File: rtl/uart_pkg.sv
// Shared types, defaults and helpers for the parametrised UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam int DEF_DATA_W       = 8;
  localparam int DEF_CLKS_PER_BIT = 5;
  localparam int DEF_STOP_BITS    = 1;

  // Callers zero-extend narrower words; extra zero bits do not change the XOR.
  function automatic logic parity_f(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud tick generator: counts 0..CLKS_PER_BIT-1 while enabled, ticks at terminal count.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 5
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
      $error("uart_baud_gen: CLKS_PER_BIT must be >= 2");
    end
  endgenerate

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= (cnt_q == TERM) ? '0 : cnt_q + 1'b1;
    end
  end

  assign tick_o = en_i && (cnt_q == TERM);

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised framed UART serialiser: start, DATA_W data bits LSB first,
// optional parity, 1 or 2 stop bits. Valid/ready host handshake, done pulse.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = DEF_STOP_BITS
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic              tx_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int BW = $clog2(DATA_W);

  generate
    if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
      $error("uart_tx_param: DATA_W must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (PARITY_EN < 0 || PARITY_EN > 1 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_par
      $error("uart_tx_param: PARITY_EN and PARITY_ODD must be 0 or 1");
    end
  endgenerate

  // Handshake: a word transfers on the rising edge where tx_valid_i && tx_ready_o;
  // tx_ready_o is high only in IDLE, and inputs are ignored outside IDLE.
  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              parity_q, parity_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;
  logic              tick;
  logic              accept;

  assign tx_ready_o = (state_q == IDLE);
  assign accept     = tx_valid_i && tx_ready_o;
  assign tx_o       = tx_q;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .clear_i  (accept),
    .en_i     (busy_o),
    .tick_o   (tick)
  );

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = START;
          shift_d   = tx_data_i;
          parity_d  = parity_f(9'(tx_data_i), 1'(PARITY_ODD));
          bit_cnt_d = '0;
          tx_d      = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == BW'(DATA_W - 1)) begin
            bit_cnt_d = '0;
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              tx_d    = parity_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            tx_d      = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        // The bit counter is reused to count stop bits.
        if (tick) begin
          if (bit_cnt_q == BW'(STOP_BITS - 1)) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            done_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

endmodule
